// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_rr
//  Purpose  : N-channel valid/ready stream mux with registered output stage,
//             fixed-select (MODE=0) or round-robin (MODE=1) arbitration.
//  Revision : 1.0  initial release
// ============================================================================
module stream_mux_rr #(
    parameter int WIDTH = 5,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_ch
);

    localparam logic [SELW-1:0] c_ptr_reset = SELW'(NCH - 1);

    logic               w_load;
    logic               w_grant_valid;
    logic [SELW-1:0]    w_grant;
    logic [WIDTH-1:0]   w_grant_data;

    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [SELW-1:0]    r_ch;

    generate
        if (NCH < 2 || NCH > 16 || (64'd1 << SELW) < 64'(NCH)) begin : g_param_check
            $error("stream_mux_rr: NCH must be 2..16 and fit in SELW bits");
        end
    endgenerate

    // The output register may take a new word when empty or being drained.
    assign w_load = !r_valid || out_ready;

    generate
        if (MODE == 0) begin : g_fixed
            always_comb begin
                w_grant       = sel;
                w_grant_valid = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    if (sel == SELW'(i) && in_valid[i]) begin
                        w_grant_valid = 1'b1;
                    end
                end
            end
        end else begin : g_rr
            logic [SELW-1:0] r_ptr;
            logic            w_unused_sel;
            int              w_dist;
            int              w_best;

            assign w_unused_sel = ^sel;

            // Distance from the channel after r_ptr, wrapping upward; the
            // valid channel nearest that start point wins.
            always_comb begin
                w_grant       = '0;
                w_grant_valid = 1'b0;
                w_best        = NCH;
                w_dist        = 0;
                for (int i = 0; i < NCH; i++) begin
                    w_dist = (i - int'(r_ptr) - 1 + 2 * NCH) % NCH;
                    if (in_valid[i] && w_dist < w_best) begin
                        w_best        = w_dist;
                        w_grant       = SELW'(i);
                        w_grant_valid = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= c_ptr_reset;
                end else if (w_grant_valid && w_load) begin
                    r_ptr <= w_grant;
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
            assign in_ready[gi] = w_load && w_grant_valid && (w_grant == SELW'(gi));
        end
    endgenerate

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == SELW'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Data and channel id only move on a transfer; a grant-less load just
    // clears valid and leaves the last word visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
        end else if (w_load) begin
            r_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_data <= w_grant_data;
                r_ch   <= w_grant;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_rr
//  Purpose  : Directed scoreboard bench for stream_mux_rr in three configs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // A: MODE=0, NCH=4, WIDTH=5
    logic [19:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [1:0]  a_sel, a_out_ch;
    logic [4:0]  a_out_data;
    logic        a_out_valid, a_out_ready;
    // B: MODE=1, NCH=4, WIDTH=5
    logic [19:0] b_in_data;
    logic [3:0]  b_in_valid, b_in_ready;
    logic [1:0]  b_sel, b_out_ch;
    logic [4:0]  b_out_data;
    logic        b_out_valid, b_out_ready;
    // C: MODE=0, NCH=3, WIDTH=8
    logic [23:0] c_in_data;
    logic [2:0]  c_in_valid, c_in_ready;
    logic [1:0]  c_sel, c_out_ch;
    logic [7:0]  c_out_data;
    logic        c_out_valid, c_out_ready;

    stream_mux_rr #(.WIDTH(5), .NCH(4), .SELW(2), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch));

    stream_mux_rr #(.WIDTH(5), .NCH(4), .SELW(2), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch));

    stream_mux_rr #(.WIDTH(8), .NCH(3), .SELW(2), .MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ch(c_out_ch));

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] qc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Each step: drive inputs just after a rising edge, check in_ready on the
    // falling edge, record the word that should emerge, advance one cycle.
    task automatic step_a(input logic [3:0] v, input logic [1:0] s, input logic ordy,
                          input logic [3:0] exp_rdy);
        a_in_valid = v; a_sel = s; a_out_ready = ordy;
        @(negedge clk);
        chk("a_in_ready", 32'(a_in_ready), 32'(exp_rdy));
        if (exp_rdy != 4'd0) begin
            int k;
            k = oh_idx(exp_rdy);
            qa.push_back({8'(k), 8'(a_in_data[k*5 +: 5])});
        end
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy);
        b_in_valid = v; b_out_ready = ordy;
        @(negedge clk);
        chk("b_in_ready", 32'(b_in_ready), 32'(exp_rdy));
        if (exp_rdy != 4'd0) begin
            int k;
            k = oh_idx(exp_rdy);
            qb.push_back({8'(k), 8'(b_in_data[k*5 +: 5])});
        end
        @(posedge clk); #1;
    endtask

    task automatic step_c(input logic [2:0] v, input logic [1:0] s, input logic ordy,
                          input logic [2:0] exp_rdy);
        c_in_valid = v; c_sel = s; c_out_ready = ordy;
        @(negedge clk);
        chk("c_in_ready", 32'(c_in_ready), 32'(exp_rdy));
        if (exp_rdy != 3'd0) begin
            int k;
            k = oh_idx({1'b0, exp_rdy});
            qc.push_back({8'(k), c_in_data[k*8 +: 8]});
        end
        @(posedge clk); #1;
    endtask

    // Monitors: every accepted output word must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL a_out: unexpected word ch=%0d data=%0h", a_out_ch, a_out_data);
            end else begin
                logic [15:0] e;
                e = qa.pop_front();
                if ({8'(a_out_ch), 8'(a_out_data)} !== e) begin
                    n_bad++;
                    $display("FAIL a_out: got ch/data %0h expected %0h",
                             {8'(a_out_ch), 8'(a_out_data)}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_bad++;
                $display("FAIL b_out: unexpected word ch=%0d data=%0h", b_out_ch, b_out_data);
            end else begin
                logic [15:0] e;
                e = qb.pop_front();
                if ({8'(b_out_ch), 8'(b_out_data)} !== e) begin
                    n_bad++;
                    $display("FAIL b_out: got ch/data %0h expected %0h",
                             {8'(b_out_ch), 8'(b_out_data)}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && c_out_valid && c_out_ready) begin
            n_cmp++;
            if (qc.size() == 0) begin
                n_bad++;
                $display("FAIL c_out: unexpected word ch=%0d data=%0h", c_out_ch, c_out_data);
            end else begin
                logic [15:0] e;
                e = qc.pop_front();
                if ({8'(c_out_ch), c_out_data} !== e) begin
                    n_bad++;
                    $display("FAIL c_out: got ch/data %0h expected %0h",
                             {8'(c_out_ch), c_out_data}, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_in_data = {5'h1F, 5'h15, 5'h11, 5'h03}; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
        b_in_data = {5'h13, 5'h12, 5'h11, 5'h10}; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
        c_in_data = {8'hC2, 8'hB1, 8'hA0};        c_in_valid = '0; c_sel = '0; c_out_ready = 1'b0;
        #12;
        chk("rst_a_valid", 32'(a_out_valid), 0);
        chk("rst_a_data",  32'(a_out_data), 0);
        chk("rst_a_ch",    32'(a_out_ch), 0);
        chk("rst_a_ready", 32'(a_in_ready), 0);
        chk("rst_b_valid", 32'(b_out_valid), 0);
        chk("rst_c_valid", 32'(c_out_valid), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- MODE=0 explicit select ----
        step_a(4'b0101, 2'd2, 1'b1, 4'b0100);
        chk("a_sel2_data", 32'(a_out_data), 32'h15);
        chk("a_sel2_ch",   32'(a_out_ch), 2);
        step_a(4'b0101, 2'd1, 1'b1, 4'b0000);
        chk("a_valid_drop", 32'(a_out_valid), 0);
        chk("a_data_kept",  32'(a_out_data), 32'h15);
        a_in_data[4:0] = 5'h0A;
        step_a(4'b0001, 2'd0, 1'b1, 4'b0001);
        chk("a_load_0a", 32'(a_out_data), 32'h0A);
        a_in_data[4:0] = 5'h00;
        for (int i = 0; i < 5; i++) begin
            step_a(4'b1111 ^ 4'(i), 2'(i), 1'b0, 4'b0000);
            chk("a_hold_data",  32'(a_out_data), 32'h0A);
            chk("a_hold_ch",    32'(a_out_ch), 0);
            chk("a_hold_valid", 32'(a_out_valid), 1);
        end
        step_a(4'b1000, 2'd3, 1'b1, 4'b1000);
        chk("a_nobubble_valid", 32'(a_out_valid), 1);
        chk("a_nobubble_data",  32'(a_out_data), 32'h1F);
        step_a(4'b1111, 2'd0, 1'b1, 4'b0001);
        step_a(4'b1111, 2'd1, 1'b1, 4'b0010);
        step_a(4'b1111, 2'd2, 1'b1, 4'b0100);
        step_a(4'b0000, 2'd0, 1'b1, 4'b0000);
        chk("a_idle_valid", 32'(a_out_valid), 0);

        // ---- MODE=1 round-robin ----
        step_b(4'b1111, 1'b1, 4'b0001);
        step_b(4'b1111, 1'b1, 4'b0010);
        step_b(4'b1111, 1'b1, 4'b0100);
        step_b(4'b1111, 1'b1, 4'b1000);
        step_b(4'b1111, 1'b1, 4'b0001);
        step_b(4'b1101, 1'b1, 4'b0100);
        step_b(4'b1101, 1'b1, 4'b1000);
        step_b(4'b1101, 1'b1, 4'b0001);
        step_b(4'b1101, 1'b1, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            step_b(4'b1111, 1'b0, 4'b0000);
            chk("b_stall_ch",   32'(b_out_ch), 2);
            chk("b_stall_data", 32'(b_out_data), 32'h12);
        end
        step_b(4'b1111, 1'b1, 4'b1000);
        step_b(4'b0000, 1'b1, 4'b0000);
        chk("b_idle_valid", 32'(b_out_valid), 0);
        step_b(4'b0100, 1'b1, 4'b0100);
        chk("b_pre_rst_valid", 32'(b_out_valid), 1);
        b_in_valid = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        chk("b_async_rst_valid", 32'(b_out_valid), 0);
        chk("b_async_rst_data",  32'(b_out_data), 0);
        chk("b_async_rst_ch",    32'(b_out_ch), 0);
        qb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        step_b(4'b1111, 1'b1, 4'b0001);
        chk("b_post_rst_ch", 32'(b_out_ch), 0);
        step_b(4'b0000, 1'b1, 4'b0000);

        // ---- NCH=3, WIDTH=8, out-of-range select ----
        step_c(3'b111, 2'd3, 1'b1, 3'b000);
        chk("c_sel3_valid", 32'(c_out_valid), 0);
        step_c(3'b111, 2'd1, 1'b1, 3'b010);
        chk("c_sel1_data", 32'(c_out_data), 32'hB1);
        step_c(3'b111, 2'd3, 1'b1, 3'b000);
        chk("c_sel3_drop", 32'(c_out_valid), 0);
        step_c(3'b100, 2'd2, 1'b1, 3'b100);
        step_c(3'b000, 2'd0, 1'b1, 3'b000);

        @(posedge clk); #1;
        chk("qa_empty", 32'(qa.size()), 0);
        chk("qb_empty", 32'(qb.size()), 0);
        chk("qc_empty", 32'(qc.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
